dm_dmi_responder: RTL and testbench

Debug Module (DM) end of the DMI bus: accepts single DMI read and write transactions from the JTAG DTM and completes each with a one-cycle dmi_finish. Implements a minimal RISC-V debug register file: dmcontrol, dmstatus, hartinfo, abstractcs, command and data0. Drives halt/resume requests to a single hart. Executes Access Register abstract commands through a hart-side request/done handshake.

---
 rtl/dm_dmi_responder_pkg.sv | 72 +++++++
 rtl/dm_dmi_responder_abstract_fsm.sv | 111 +++++++++++
 rtl/dm_dmi_responder.sv | 217 +++++++++++++++++++++
 tb/tb_dm_dmi_responder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_dmi_responder_pkg.sv
// Shared types for the DMI-side debug module: register addresses, register
// layouts, DMI op codes and abstract-command error codes.
package dm_dmi_responder_pkg;

    localparam logic [6:0] ADDR_DATA0        = 7'h04;
    localparam logic [6:0] ADDR_DMCONTROL    = 7'h10;
    localparam logic [6:0] ADDR_DMSTATUS     = 7'h11;
    localparam logic [6:0] ADDR_HARTINFO     = 7'h12;
    localparam logic [6:0] ADDR_ABSTRACTCS   = 7'h16;
    localparam logic [6:0] ADDR_COMMAND      = 7'h17;
    localparam logic [6:0] ADDR_ABSTRACTAUTO = 7'h18;

    typedef enum logic [1:0] {
        DMI_NOP   = 2'd0,
        DMI_READ  = 2'd1,
        DMI_WRITE = 2'd2,
        DMI_RSVD  = 2'd3
    } dmi_op_e;

    typedef enum logic [2:0] {
        CMDERR_NONE       = 3'd0,
        CMDERR_BUSY       = 3'd1,
        CMDERR_NOTSUP     = 3'd2,
        CMDERR_EXCEPTION  = 3'd3,
        CMDERR_HALTRESUME = 3'd4
    } cmderr_e;

    typedef struct packed {
        logic        haltreq;
        logic        resumereq;
        logic [27:0] rsvd;
        logic        ndmreset;
        logic        dmactive;
    } dmcontrol_t;

    typedef struct packed {
        logic [13:0] rsvd_hi;
        logic        allresumeack;
        logic        anyresumeack;
        logic [3:0]  rsvd_mid;
        logic        allrunning;
        logic        anyrunning;
        logic        allhalted;
        logic        anyhalted;
        logic        authenticated;
        logic [2:0]  rsvd_lo;
        logic [3:0]  version;
    } dmstatus_t;

    typedef struct packed {
        logic [2:0]  rsvd_hi;
        logic [4:0]  progbufsize;
        logic [10:0] rsvd_mid;
        logic        busy;
        logic        rsvd_b11;
        logic [2:0]  cmderr;
        logic [3:0]  rsvd_lo;
        logic [3:0]  datacount;
    } abstractcs_t;

    typedef struct packed {
        logic [7:0]  cmdtype;
        logic        rsvd;
        logic [2:0]  aarsize;
        logic        aarpostincrement;
        logic        postexec;
        logic        transfer;
        logic        write;
        logic [15:0] regno;
    } command_t;

endpackage

// File: rtl/dm_dmi_responder_abstract_fsm.sv
// Abstract command engine: validates Access Register commands, tracks busy
// and cmderr, and runs the ar_* request/done handshake with the hart.
module dm_abstract_fsm
    import dm_dmi_responder_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clear,
    input  logic        i_cmd_wr,
    input  logic [31:0] i_cmd,
    input  logic        i_autoexec,
    input  logic        i_cmderr_w1c,
    input  logic [2:0]  i_cmderr_clr,
    input  logic        i_data0_busy_wr,
    input  logic        i_halted,
    input  logic [31:0] i_data0,
    output logic        o_busy,
    output logic [2:0]  o_cmderr,
    output logic        o_data0_ld,
    output logic        o_ar_valid,
    output logic        o_ar_write,
    output logic [15:0] o_ar_regno,
    output logic [31:0] o_ar_wdata,
    input  logic        i_ar_done,
    input  logic        i_ar_err
);

    typedef enum logic {AB_IDLE, AB_BUSY} ab_state_e;

    ab_state_e   r_state;
    logic [2:0]  r_cmderr;
    logic        r_ar_valid;
    logic        r_ar_write;
    logic [15:0] r_ar_regno;
    logic [31:0] r_ar_wdata;
    command_t    r_last_cmd;

    logic        w_issue;
    command_t    w_cmd;
    logic        w_notsup;
    logic        w_unused;

    // autoexec replays the last command accepted through a command write
    assign w_issue  = i_cmd_wr || i_autoexec;
    assign w_cmd    = i_cmd_wr ? command_t'(i_cmd) : r_last_cmd;
    assign w_notsup = (w_cmd.cmdtype != 8'd0) || (w_cmd.aarsize != 3'd2) ||
                      w_cmd.postexec || w_cmd.aarpostincrement;
    assign w_unused = w_cmd.rsvd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= AB_IDLE;
            r_cmderr   <= CMDERR_NONE;
            r_ar_valid <= 1'b0;
            r_ar_write <= 1'b0;
            r_ar_regno <= '0;
            r_ar_wdata <= '0;
            r_last_cmd <= '0;
        end else if (i_clear) begin
            r_state    <= AB_IDLE;
            r_cmderr   <= CMDERR_NONE;
            r_ar_valid <= 1'b0;
            r_ar_write <= 1'b0;
            r_ar_regno <= '0;
            r_ar_wdata <= '0;
            r_last_cmd <= '0;
        end else begin
            if (i_cmderr_w1c)
                r_cmderr <= r_cmderr & ~i_cmderr_clr;
            case (r_state)
                AB_IDLE: begin
                    if (w_issue && r_cmderr == CMDERR_NONE) begin
                        if (i_cmd_wr)
                            r_last_cmd <= command_t'(i_cmd);
                        if (w_notsup)
                            r_cmderr <= CMDERR_NOTSUP;
                        else if (w_cmd.transfer && !i_halted)
                            r_cmderr <= CMDERR_HALTRESUME;
                        else if (w_cmd.transfer) begin
                            r_state    <= AB_BUSY;
                            r_ar_valid <= 1'b1;
                            r_ar_write <= w_cmd.write;
                            r_ar_regno <= w_cmd.regno;
                            r_ar_wdata <= i_data0;
                        end
                    end
                end
                AB_BUSY: begin
                    if (i_ar_done) begin
                        r_state    <= AB_IDLE;
                        r_ar_valid <= 1'b0;
                        if (i_ar_err && r_cmderr == CMDERR_NONE)
                            r_cmderr <= CMDERR_EXCEPTION;
                    end else if ((i_cmd_wr || i_data0_busy_wr) && r_cmderr == CMDERR_NONE) begin
                        r_cmderr <= CMDERR_BUSY;
                    end
                end
                default: r_state <= AB_IDLE;
            endcase
        end
    end

    assign o_busy     = (r_state == AB_BUSY);
    assign o_cmderr   = r_cmderr;
    assign o_data0_ld = (r_state == AB_BUSY) && i_ar_done && !r_ar_write;
    assign o_ar_valid = r_ar_valid;
    assign o_ar_write = r_ar_write;
    assign o_ar_regno = r_ar_regno;
    assign o_ar_wdata = r_ar_wdata;

endmodule

// File: rtl/dm_dmi_responder.sv
// DMI responder for a minimal single-hart debug module.
// Optional abstractauto register (data0 autoexec) enabled by DM_AUTOEXEC_EN.
module dm_dmi_responder
    import dm_dmi_responder_pkg::*;
#(
    parameter int          ABITS          = 7,
    parameter logic [31:0] HARTINFO_VALUE = 32'h0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dmi_start,
    input  logic [1:0]       dmi_op,
    input  logic [ABITS-1:0] dmi_address,
    input  logic [31:0]      dmi_data_i,
    output logic [31:0]      dmi_data_o,
    output logic             dmi_finish,
    output logic             dmactive,
    output logic             ndmreset,
    output logic             haltreq,
    output logic             resumereq,
    input  logic             halted,
    input  logic             resumeack,
    output logic             ar_valid,
    output logic             ar_write,
    output logic [15:0]      ar_regno,
    output logic [31:0]      ar_wdata,
    input  logic [31:0]      ar_rdata,
    input  logic             ar_done,
    input  logic             ar_err
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESPOND} dmi_state_e;

    dmi_state_e       r_state;
    logic [1:0]       r_op;
    logic [ABITS-1:0] r_addr;
    logic [31:0]      r_wdata;
    logic [31:0]      r_rdata;
    logic             r_finish;
    logic             r_dmactive;
    logic             r_ndmreset;
    logic             r_haltreq;
    logic             r_resumereq;
    logic             r_resumeack;
    logic [31:0]      r_data0;

    logic             w_rd;
    logic             w_wr;
    logic             w_busy;
    logic [2:0]       w_cmderr;
    logic             w_data0_ld;
    logic             w_autoexec;
    logic [31:0]      w_auto_rd;
    logic [31:0]      w_rdata;
    dmcontrol_t       w_dmc;
    dmstatus_t        w_dmstatus;
    abstractcs_t      w_abstractcs;
    logic             w_unused;

    assign w_rd     = (r_state == S_ACCESS) && (r_op == DMI_READ);
    assign w_wr     = (r_state == S_ACCESS) && (r_op == DMI_WRITE);
    assign w_dmc    = dmcontrol_t'(r_wdata);
    assign w_unused = ^w_dmc.rsvd;

    always_comb begin
        w_dmstatus               = '0;
        w_dmstatus.version       = 4'd2;
        w_dmstatus.authenticated = 1'b1;
        w_dmstatus.anyhalted     = halted;
        w_dmstatus.allhalted     = halted;
        w_dmstatus.anyrunning    = !halted;
        w_dmstatus.allrunning    = !halted;
        w_dmstatus.anyresumeack  = r_resumeack;
        w_dmstatus.allresumeack  = r_resumeack;
        w_abstractcs             = '0;
        w_abstractcs.datacount   = 4'd1;
        w_abstractcs.cmderr      = w_cmderr;
        w_abstractcs.busy        = w_busy;
    end

    always_comb begin
        w_rdata = '0;
        case (r_addr)
            ABITS'(ADDR_DATA0):        w_rdata = r_data0;
            ABITS'(ADDR_DMCONTROL):    w_rdata = {r_haltreq, r_resumereq, 28'd0, r_ndmreset, r_dmactive};
            ABITS'(ADDR_DMSTATUS):     w_rdata = w_dmstatus;
            ABITS'(ADDR_HARTINFO):     w_rdata = HARTINFO_VALUE;
            ABITS'(ADDR_ABSTRACTCS):   w_rdata = w_abstractcs;
            ABITS'(ADDR_ABSTRACTAUTO): w_rdata = w_auto_rd;
            default:                   w_rdata = '0;
        endcase
    end

`ifdef DM_AUTOEXEC_EN
    logic r_autoexecdata;
    logic r_auto_pend;

    // fire one cycle after the data0 access so a written data0 is what gets sent
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_autoexecdata <= 1'b0;
            r_auto_pend    <= 1'b0;
        end else if (!r_dmactive) begin
            r_autoexecdata <= 1'b0;
            r_auto_pend    <= 1'b0;
        end else begin
            if (w_wr && r_addr == ABITS'(ADDR_ABSTRACTAUTO))
                r_autoexecdata <= r_wdata[0];
            r_auto_pend <= (w_rd || w_wr) && (r_addr == ABITS'(ADDR_DATA0)) &&
                           r_autoexecdata && !w_busy;
        end
    end

    assign w_autoexec = r_auto_pend;
    assign w_auto_rd  = {31'd0, r_autoexecdata};
`else
    assign w_autoexec = 1'b0;
    assign w_auto_rd  = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_finish    <= 1'b0;
            r_dmactive  <= 1'b0;
            r_ndmreset  <= 1'b0;
            r_haltreq   <= 1'b0;
            r_resumereq <= 1'b0;
            r_resumeack <= 1'b0;
            r_data0     <= '0;
        end else begin
            r_finish <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (dmi_start) begin
                        r_op    <= dmi_op;
                        r_addr  <= dmi_address;
                        r_wdata <= dmi_data_i;
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    r_rdata  <= w_rd ? w_rdata : '0;
                    r_finish <= 1'b1;
                    r_state  <= S_RESPOND;
                end
                S_RESPOND: r_state <= S_IDLE;
                default:   r_state <= S_IDLE;
            endcase

            if (r_dmactive && resumeack) begin
                r_resumereq <= 1'b0;
                r_resumeack <= 1'b1;
            end

            if (w_wr && r_addr == ABITS'(ADDR_DMCONTROL)) begin
                r_dmactive <= w_dmc.dmactive;
                if (!w_dmc.dmactive) begin
                    r_ndmreset  <= 1'b0;
                    r_haltreq   <= 1'b0;
                    r_resumereq <= 1'b0;
                    r_resumeack <= 1'b0;
                end else begin
                    r_ndmreset <= w_dmc.ndmreset;
                    r_haltreq  <= w_dmc.haltreq;
                    // haltreq takes priority over a simultaneous resumereq
                    if (w_dmc.resumereq && !w_dmc.haltreq) begin
                        r_resumereq <= 1'b1;
                        r_resumeack <= 1'b0;
                    end
                end
            end

            if (!r_dmactive)
                r_data0 <= '0;
            else if (w_data0_ld)
                r_data0 <= ar_rdata;
            else if (w_wr && r_addr == ABITS'(ADDR_DATA0) && !w_busy)
                r_data0 <= r_wdata;
        end
    end

    dm_abstract_fsm u_abs (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_clear         (!r_dmactive),
        .i_cmd_wr        (w_wr && r_addr == ABITS'(ADDR_COMMAND)),
        .i_cmd           (r_wdata),
        .i_autoexec      (w_autoexec),
        .i_cmderr_w1c    (w_wr && r_addr == ABITS'(ADDR_ABSTRACTCS)),
        .i_cmderr_clr    (r_wdata[10:8]),
        .i_data0_busy_wr (w_wr && r_addr == ABITS'(ADDR_DATA0) && w_busy),
        .i_halted        (halted),
        .i_data0         (r_data0),
        .o_busy          (w_busy),
        .o_cmderr        (w_cmderr),
        .o_data0_ld      (w_data0_ld),
        .o_ar_valid      (ar_valid),
        .o_ar_write      (ar_write),
        .o_ar_regno      (ar_regno),
        .o_ar_wdata      (ar_wdata),
        .i_ar_done       (ar_done),
        .i_ar_err        (ar_err)
    );

    assign dmi_data_o = r_rdata;
    assign dmi_finish = r_finish;
    assign dmactive   = r_dmactive;
    assign ndmreset   = r_ndmreset;
    assign haltreq    = r_haltreq;
    assign resumereq  = r_resumereq;

endmodule

// File: tb/tb_dm_dmi_responder.sv
// Directed bench: DMI read data checked by a scoreboard/monitor pair,
// hart-side signals checked directly after each transaction.
module tb_dm_dmi_responder;

    localparam logic [31:0] HINFO = 32'h0012_3456;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dmi_start = 1'b0;
    logic [1:0]  dmi_op = 2'd0;
    logic [6:0]  dmi_address = 7'd0;
    logic [31:0] dmi_data_i = 32'd0;
    logic [31:0] dmi_data_o;
    logic        dmi_finish, dmactive, ndmreset, haltreq, resumereq;
    logic        halted = 1'b0;
    logic        resumeack = 1'b0;
    logic        ar_valid, ar_write;
    logic [15:0] ar_regno;
    logic [31:0] ar_wdata;
    logic [31:0] ar_rdata = 32'd0;
    logic        ar_done = 1'b0;
    logic        ar_err = 1'b0;

    always #5 clk = ~clk;

    dm_dmi_responder #(.ABITS(7), .HARTINFO_VALUE(HINFO)) dut (
        .clk(clk), .rst_n(rst_n), .dmi_start(dmi_start), .dmi_op(dmi_op),
        .dmi_address(dmi_address), .dmi_data_i(dmi_data_i), .dmi_data_o(dmi_data_o),
        .dmi_finish(dmi_finish), .dmactive(dmactive), .ndmreset(ndmreset),
        .haltreq(haltreq), .resumereq(resumereq), .halted(halted), .resumeack(resumeack),
        .ar_valid(ar_valid), .ar_write(ar_write), .ar_regno(ar_regno), .ar_wdata(ar_wdata),
        .ar_rdata(ar_rdata), .ar_done(ar_done), .ar_err(ar_err)
    );

    typedef struct {
        logic        chk;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // monitor: every dmi_finish consumes one scoreboard entry
    always @(negedge clk) begin
        if (rst_n && dmi_finish) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_finish: got data %h expected no finish", dmi_data_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.chk) chk(e.name, dmi_data_o, e.val);
            end
        end
    end

    task automatic dmi(input logic [1:0] op, input logic [6:0] a, input logic [31:0] d,
                       input logic c, input logic [31:0] e, input string nm);
        exp_t x;
        @(negedge clk);
        dmi_start = 1'b1; dmi_op = op; dmi_address = a; dmi_data_i = d;
        x.chk = c; x.val = e; x.name = nm;
        sb.push_back(x);
        @(negedge clk);
        dmi_start = 1'b0;
        chk({nm, "_early"}, 32'(dmi_finish), 32'd0);
        @(negedge clk);
        chk({nm, "_latency"}, 32'(dmi_finish), 32'd1);
    endtask

    task automatic rd(input logic [6:0] a, input logic [31:0] e, input string nm);
        dmi(2'd1, a, 32'd0, 1'b1, e, nm);
    endtask

    task automatic wr(input logic [6:0] a, input logic [31:0] d);
        dmi(2'd2, a, d, 1'b0, 32'd0, "wr");
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic done_pulse(input logic err);
        @(negedge clk); ar_done = 1'b1; ar_err = err;
        @(negedge clk); ar_done = 1'b0; ar_err = 1'b0;
    endtask

    task automatic ack_pulse();
        @(negedge clk); resumeack = 1'b1;
        @(negedge clk); resumeack = 1'b0;
    endtask

    task automatic chk_outs_zero(input string nm);
        chk({nm, "_data_o"}, dmi_data_o, 32'd0);
        chk({nm, "_ctl"}, 32'({dmi_finish, dmactive, ndmreset, haltreq, resumereq,
                                ar_valid, ar_write, ar_regno}), 32'd0);
        chk({nm, "_ar_wdata"}, ar_wdata, 32'd0);
    endtask

    initial begin
        idle(3);
        chk_outs_zero("reset");
        rst_n = 1'b1;

        // dmstatus is live even while inactive
        halted = 1'b1;
        rd(7'h11, 32'h0000_0382, "dmstatus_halted");

        // basic register file and dmactive gating
        wr(7'h10, 32'h1);
        chk("dmactive_set", 32'(dmactive), 32'd1);
        wr(7'h04, 32'hDEAD_BEEF);
        rd(7'h04, 32'hDEAD_BEEF, "data0_rw");
        rd(7'h12, HINFO, "hartinfo");
        rd(7'h16, 32'h0000_0001, "abstractcs_idle");
        rd(7'h17, 32'h0, "command_reads_0");
        wr(7'h10, 32'h0);
        chk("dmactive_clr", 32'(dmactive), 32'd0);
        rd(7'h04, 32'h0, "data0_inactive");
        wr(7'h04, 32'h1111_1111);
        wr(7'h10, 32'h1);
        rd(7'h04, 32'h0, "data0_wr_ignored_inactive");

        // abstract write command
        wr(7'h04, 32'hCAFE_F00D);
        wr(7'h17, 32'h0023_1000);
        chk("ar_valid_wcmd", 32'(ar_valid), 32'd1);
        chk("ar_write_wcmd", 32'(ar_write), 32'd1);
        chk("ar_regno_wcmd", 32'(ar_regno), 32'h1000);
        chk("ar_wdata_wcmd", ar_wdata, 32'hCAFE_F00D);
        rd(7'h16, 32'h0000_1001, "abstractcs_busy");
        idle(2);
        done_pulse(1'b0);
        chk("ar_valid_after_done", 32'(ar_valid), 32'd0);
        rd(7'h16, 32'h0000_0001, "abstractcs_done");
        rd(7'h04, 32'hCAFE_F00D, "data0_kept_after_wcmd");

        // command while busy, then W1C
        wr(7'h17, 32'h0023_1000);
        wr(7'h17, 32'h0023_1000);
        rd(7'h16, 32'h0000_1101, "abstractcs_busyerr");
        done_pulse(1'b0);
        rd(7'h16, 32'h0000_0101, "cmderr_sticky");
        wr(7'h16, 32'h700);
        rd(7'h16, 32'h0000_0001, "cmderr_w1c");

        // abstract read command, data0 access while busy
        ar_rdata = 32'h1234_5678;
        wr(7'h17, 32'h0022_1001);
        chk("ar_write_rcmd", 32'(ar_write), 32'd0);
        chk("ar_regno_rcmd", 32'(ar_regno), 32'h1001);
        wr(7'h04, 32'h9999_9999);
        rd(7'h04, 32'hCAFE_F00D, "data0_stale_busy");
        done_pulse(1'b0);
        rd(7'h04, 32'h1234_5678, "data0_from_hart");
        rd(7'h16, 32'h0000_0101, "cmderr_data0_busy");
        wr(7'h16, 32'h700);
        ar_rdata = 32'hAAAA_5555;
        wr(7'h17, 32'h0022_1001);
        done_pulse(1'b1);
        rd(7'h16, 32'h0000_0301, "cmderr_exception");
        wr(7'h16, 32'h700);
        rd(7'h16, 32'h0000_0001, "cmderr_exc_cleared");

        // validation errors
        wr(7'h17, 32'h0033_1001);
        rd(7'h16, 32'h0000_0201, "notsup_aarsize");
        wr(7'h16, 32'h700);
        wr(7'h17, 32'h0026_1001);
        rd(7'h16, 32'h0000_0201, "notsup_postexec");
        wr(7'h16, 32'h700);
        halted = 1'b0;
        wr(7'h17, 32'h0022_1001);
        chk("ar_valid_not_halted", 32'(ar_valid), 32'd0);
        rd(7'h16, 32'h0000_0401, "haltresume_err");
        wr(7'h16, 32'h700);
        wr(7'h17, 32'h0020_0000);
        chk("ar_valid_no_transfer", 32'(ar_valid), 32'd0);
        rd(7'h16, 32'h0000_0001, "no_transfer_ok");
        wr(7'h17, 32'h0120_0000);
        halted = 1'b1;
        wr(7'h17, 32'h0023_1000);
        chk("ar_valid_cmderr_pending", 32'(ar_valid), 32'd0);
        rd(7'h16, 32'h0000_0201, "notsup_cmdtype_kept");
        wr(7'h16, 32'h700);

        // unmapped addresses and no-op ops
        wr(7'h05, 32'hFFFF_FFFF);
        rd(7'h05, 32'h0, "unmapped_05");
        rd(7'h12, HINFO, "hartinfo_again");
        dmi(2'd0, 7'h12, 32'h0, 1'b1, 32'h0, "op0");
        rd(7'h12, HINFO, "hartinfo_again2");
        dmi(2'd3, 7'h04, 32'h5, 1'b1, 32'h0, "op3");
        rd(7'h04, 32'hAAAA_5555, "data0_after_nops");
        wr(7'h18, 32'h1);
`ifdef DM_AUTOEXEC_EN
        rd(7'h18, 32'h1, "abstractauto");
`else
        rd(7'h18, 32'h0, "abstractauto");
`endif
        wr(7'h18, 32'h0);

        // dmactive=0 aborts an in-flight command
        wr(7'h17, 32'h0023_1000);
        chk("ar_valid_pre_abort", 32'(ar_valid), 32'd1);
        wr(7'h10, 32'h0);
        idle(1);
        chk("ar_valid_aborted", 32'(ar_valid), 32'd0);
        wr(7'h10, 32'h1);
        rd(7'h16, 32'h0000_0001, "abstractcs_after_abort");

        // resume handshake
        halted = 1'b0;
        wr(7'h10, 32'h4000_0001);
        chk("resumereq_set", 32'(resumereq), 32'd1);
        rd(7'h11, 32'h0000_0C82, "dmstatus_running");
        idle(3);
        chk("resumereq_held", 32'(resumereq), 32'd1);
        ack_pulse();
        chk("resumereq_dropped", 32'(resumereq), 32'd0);
        rd(7'h11, 32'h0003_0C82, "dmstatus_resumeack");
        wr(7'h10, 32'hC000_0001);
        chk("haltreq_wins", 32'(haltreq), 32'd1);
        chk("resumereq_ignored", 32'(resumereq), 32'd0);
        rd(7'h11, 32'h0003_0C82, "resumeack_not_cleared");
        wr(7'h10, 32'h1);
        chk("haltreq_clr", 32'(haltreq), 32'd0);
        wr(7'h10, 32'h4000_0001);
        rd(7'h11, 32'h0000_0C82, "resumeack_cleared");
        ack_pulse();

        // asynchronous reset in the middle of a transaction
        wr(7'h10, 32'h3);
        chk("ndmreset_set", 32'(ndmreset), 32'd1);
        halted = 1'b1;
        wr(7'h04, 32'h55AA_55AA);
        wr(7'h17, 32'h0023_1000);
        rd(7'h12, HINFO, "pre_reset_read");
        @(negedge clk);
        dmi_start = 1'b1; dmi_op = 2'd1; dmi_address = 7'h11;
        @(negedge clk);
        dmi_start = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_outs_zero("midreset");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_finish_in_reset", 32'(dmi_finish), 32'd0);
        end
        rst_n = 1'b1;
        rd(7'h04, 32'h0, "data0_after_reset");
        rd(7'h11, 32'h0000_0382, "dmstatus_after_reset");

        idle(2);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
